// File: rtl/led_blinker_pkg.sv
// -----------------------------------------------------------------------------
// led_blinker_pkg
// Shared types and constants for the LED blinker.
//   mode_e       : 3-bit channel mode code (OFF/ON/BLINK/BREATHE/PULSE)
//   PERIOD_W     : width of the per-channel period field, in ticks
//   PHASE_W      : width of the per-channel phase counter
//   decode_mode  : maps a raw 3-bit code onto mode_e; unused codes fold to OFF
// -----------------------------------------------------------------------------
package led_blinker_pkg;

  localparam int PERIOD_W = 16;
  localparam int PHASE_W  = 16;
  localparam int MODE_W   = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_BREATHE = 3'd3,
    MODE_PULSE   = 3'd4
  } mode_e;

  // Codes 5..7 are stored as OFF so the mode register always holds a
  // legal enum value and downstream case statements need no special arms.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] code);
    mode_e m;
    case (code)
      3'd1:    m = MODE_ON;
      3'd2:    m = MODE_BLINK;
      3'd3:    m = MODE_BREATHE;
      3'd4:    m = MODE_PULSE;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// One independent LED channel: holds mode/period/phase/level/dir and produces
// a registered LED drive and a registered "in PULSE mode" flag.
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   tick_i         : one-cycle timebase tick shared by all channels
//   pwm_cnt_i      : shared free-running PWM counter
//   wr_i           : configuration write aimed at this channel
//   wr_mode_i      : raw mode code of the write
//   wr_period_i    : period (ticks) of the write
//   led_o          : registered LED drive, 1 = lit
//   pulse_active_o : registered, high while the channel is in PULSE mode
// -----------------------------------------------------------------------------
module led_channel
  import led_blinker_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wr_i,
  input  logic [MODE_W-1:0]   wr_mode_i,
  input  logic [PERIOD_W-1:0] wr_period_i,
  output logic                led_o,
  output logic                pulse_active_o
);

  localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PHASE_W-1:0]  PHASE_ONE = PHASE_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);

  mode_e                mode_q,   mode_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PHASE_W-1:0]   phase_q,  phase_d;
  logic [PWM_BITS-1:0]  level_q,  level_d;
  logic                 down_q,   down_d;    // breathe direction, 0 = up
  logic                 led_q,    led_d;
  logic                 pulse_q,  pulse_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      phase_q  <= '0;
      level_q  <= '0;
      down_q   <= 1'b0;
      led_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      level_q  <= level_d;
      down_q   <= down_d;
      led_q    <= led_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next-state logic. A write replaces the whole channel state, so any tick
  // or pulse expiry on the same edge is simply dropped.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    phase_d  = phase_q;
    level_d  = level_q;
    down_d   = down_q;
    if (wr_i) begin
      mode_d   = decode_mode(wr_mode_i);
      period_d = wr_period_i;
      phase_d  = '0;
      level_d  = '0;
      down_d   = 1'b0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (period_q <= PER_ONE) begin
            phase_d = '0;
          end else if (tick_i) begin
            // >= rather than == keeps the counter bounded even if phase
            // ever exceeds the period.
            phase_d = (phase_q >= period_q - PER_ONE) ? '0 : phase_q + PHASE_ONE;
          end
        end
        MODE_BREATHE: begin
          if (tick_i) begin
            if (!down_q) begin
              level_d = level_q + LEVEL_ONE;
              if (level_q == LEVEL_MAX - LEVEL_ONE) down_d = 1'b1;
            end else begin
              level_d = level_q - LEVEL_ONE;
              if (level_q == LEVEL_ONE) down_d = 1'b0;
            end
          end
        end
        MODE_PULSE: begin
          if (period_q == '0) begin
            mode_d = MODE_OFF;
          end else if (tick_i) begin
            // Expire on the tick that finds phase at period-1, giving a
            // pulse of 'period' ticks.
            if (phase_q >= period_q - PER_ONE) begin
              mode_d  = MODE_OFF;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PHASE_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from current state; registered in the state register.
  always_comb begin
    led_d   = 1'b0;
    pulse_d = 1'b0;
    case (mode_q)
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = (period_q <= PER_ONE) ? 1'b1 : (phase_q < (period_q >> 1));
      MODE_BREATHE: led_d = (pwm_cnt_i < level_q);
      MODE_PULSE: begin
        led_d   = (period_q != '0);
        pulse_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign led_o          = led_q;
  assign pulse_active_o = pulse_q;

endmodule

// File: rtl/led_blinker.sv
// -----------------------------------------------------------------------------
// led_blinker
// Multi-channel LED driver: OFF / ON / BLINK / BREATHE (PWM) / one-shot PULSE.
// A shared prescaler produces a one-cycle tick every CLK_HZ/TICK_HZ cycles and
// a shared free-running counter provides the PWM ramp for BREATHE.
//   clk50        : sole clock
//   rst          : synchronous active-high reset
//   cfg_we       : one-cycle configuration write strobe
//   cfg_ch       : target channel; indices >= NUM_LEDS are ignored
//   cfg_mode     : mode code (0 OFF, 1 ON, 2 BLINK, 3 BREATHE, 4 PULSE)
//   cfg_period   : period in ticks
//   led          : registered LED drives, 1 = lit
//   pulse_active : registered, high per channel while in PULSE mode
// CLK_HZ/TICK_HZ must be an integer of at least 2.
// -----------------------------------------------------------------------------
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] pulse_active
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic                tick;

  // Tick is decoded from the prescaler, so it is cleared together with it and
  // the first tick after reset lands DIV edges after the reset edge.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
    logic wr_sel;
    // Out-of-range channel indices match no instance, so those writes vanish.
    assign wr_sel = cfg_we && (cfg_ch == 4'(gi));

    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_i          (clk50),
      .rst_i          (rst),
      .tick_i         (tick),
      .pwm_cnt_i      (pwm_q),
      .wr_i           (wr_sel),
      .wr_mode_i      (cfg_mode),
      .wr_period_i    (cfg_period),
      .led_o          (led[gi]),
      .pulse_active_o (pulse_active[gi])
    );
  end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter NUM_LEDS, default 4, is the number of independent LED channels (1..16).
REQ-002 Parameter CLK_HZ, default 50000000, is the clk50 frequency in Hz.
REQ-003 Parameter TICK_HZ, default 1000, is the timebase tick rate; DIV = CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-004 Parameter PWM_BITS, default 8, is the breathe brightness/PWM resolution.
REQ-005 clk50  in  1  sole clock; all state on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 cfg_we  in  1  one-cycle write strobe.
REQ-008 cfg_ch  in  4  target channel index.
REQ-009 cfg_mode  in  3  mode code (see REQ-013).
REQ-010 cfg_period  in  16  period in ticks.
REQ-011 led  out  NUM_LEDS  registered LED drive, 1 = lit.
REQ-012 pulse_active  out  NUM_LEDS  high while channel is in PULSE mode.

Function
REQ-013 Mode codes: OFF=0, ON=1, BLINK=2, BREATHE=3, PULSE=4; codes 5-7 SHALL behave as OFF.
REQ-014 Prescaler counts 0..DIV-1 and wraps; internal tick is high for exactly the one cycle where the count = DIV-1.
REQ-015 Free-running PWM counter of PWM_BITS wraps from 2^PWM_BITS-1 to 0 every clk50 cycle.
REQ-016 Per channel state: mode (3b), period (16b), phase (16b), level (PWM_BITS), dir (1b).
REQ-017 Write with cfg_we=1 and cfg_ch < NUM_LEDS: on that edge, mode <= cfg_mode, period <= cfg_period, phase <= 0, level <= 0, dir <= up.
REQ-018 Write with cfg_ch >= NUM_LEDS SHALL be ignored; no state changes.
REQ-019 Write and tick in the same cycle on the same channel: the write wins, and that tick is discarded for that channel.
REQ-020 OFF: led = 0. ON: led = 1.
REQ-021 BLINK: on each tick, phase increments and wraps from period-1 to 0; led = 1 while phase < period>>1 (floor).
REQ-022 BLINK with period 0 or 1: led = 1 constantly, and phase stays 0.
REQ-023 BREATHE: on each tick, level steps by 1 in direction dir; dir reverses on reaching 2^PWM_BITS-1 (going up) or 0 (going down); period is ignored.
REQ-024 BREATHE: led = 1 when pwm_cnt < level; level 0 gives always off.
REQ-025 PULSE: led = 1; on each tick phase increments; on the tick where phase reaches period-1, mode <= OFF.
REQ-026 PULSE with period 0: mode <= OFF on the next edge; led is never driven high.
REQ-027 A write on the same edge as a PULSE expiry SHALL win.
REQ-028 led and pulse_active are registered from channel state: a write at edge N shows on the outputs after edge N+1.
REQ-029 Channels are fully independent; a write to one channel SHALL NOT disturb any other channel's phase or level.

Reset
REQ-030 While rst=1 at an edge, the following SHALL be cleared: all modes (to OFF), period, phase, level, dir (to up), the prescaler, the PWM counter, tick, led, and pulse_active.
REQ-031 Reset SHALL take precedence over cfg_we and tick, including in the middle of a PULSE or BLINK.
REQ-032 The first tick after reset release SHALL occur DIV cycles later.

Structure
REQ-033 Package led_blinker_pkg SHALL hold the mode codes as a 3-bit enum type plus the period and phase width constants.
REQ-034 Per-channel logic SHALL be sub-module led_channel, instantiated NUM_LEDS times in a generate loop; the prescaler and PWM counter are shared in the top level.

Verification (CLK_HZ=1000, TICK_HZ=100 -> DIV=10; PWM_BITS=8)
REQ-035 Write ch0 BLINK, period=4 -> led[0] is high for 20 cycles, then low for 20 cycles, repeating; other LEDs stay 0.
REQ-036 Write ch1 PULSE, period=3 -> led[1] and pulse_active[1] are high for 3 ticks, then both drop to 0 and mode reads OFF; with period=0 -> led[1] never goes high.
REQ-037 Write ch2 BREATHE -> after 128 ticks, led[2] is high for 128 of 256 cycles; level peaks at 255 after 255 ticks, then decreases.
REQ-038 Write with cfg_ch=4 (NUM_LEDS=4) -> all outputs and states are unchanged; a write coincident with a tick -> phase = 0 on the next cycle.
REQ-039 Assert rst mid-PULSE -> led=0 and pulse_active=0 at the next edge; after release, no tick occurs for 10 cycles.
